// File: rtl/vector_exec_ctrl_pkg.sv
// Shared definitions for the vector execute controller.
//   - default geometry (element width, words per vector, scalar width, vreg index width)
//   - SEW codes, VFU status codes, controller FSM states
//   - sew_shift(): log2 of the element width in bits, unknown codes map to one byte
package vector_exec_ctrl_pkg;

    localparam int unsigned DEFAULT_DATA_LEN       = 32;
    localparam int unsigned DEFAULT_VECTOR_SIZE    = 8;
    localparam int unsigned DEFAULT_SCALAR_REG_LEN = 64;
    localparam int unsigned DEFAULT_VREG_ADDR      = 5;
    localparam int unsigned DEFAULT_VLEN           = DEFAULT_VECTOR_SIZE * DEFAULT_DATA_LEN;

    typedef enum logic [2:0] {
        SEW_ONE_BYTE   = 3'd0,
        SEW_TWO_BYTE   = 3'd1,
        SEW_FOUR_BYTE  = 3'd2,
        SEW_EIGHT_BYTE = 3'd3
    } sew_e;

    typedef enum logic [1:0] {
        VEC_ALU_NOP      = 2'd0,
        VEC_ALU_WORKING  = 2'd1,
        VEC_ALU_FINISHED = 2'd2
    } vfu_status_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

    function automatic logic [31:0] sew_shift(input logic [2:0] vsew);
        case (vsew)
            SEW_TWO_BYTE:   return 32'd4;
            SEW_FOUR_BYTE:  return 32'd5;
            SEW_EIGHT_BYTE: return 32'd6;
            default:        return 32'd3;
        endcase
    endfunction

endpackage

// File: rtl/vector_exec_ctrl_if.sv
// Decode/VFU/VRF signal bundle of the vector execute controller.
//   master : the controller (consumes decoded ops, drives VFU request and VRF write)
//   slave  : the surrounding pipeline (issue stage, VFU, VRF write port)
// Signal names match the original flat port list of vector_exec_ctrl.
interface vector_exec_ctrl_if
    import vector_exec_ctrl_pkg::*;
#(
    parameter int unsigned DATA_LEN       = DEFAULT_DATA_LEN,
    parameter int unsigned VECTOR_SIZE    = DEFAULT_VECTOR_SIZE,
    parameter int unsigned SCALAR_REG_LEN = DEFAULT_SCALAR_REG_LEN,
    parameter int unsigned VREG_ADDR      = DEFAULT_VREG_ADDR
);
    localparam int unsigned VLEN = VECTOR_SIZE * DATA_LEN;

    logic                      in_valid;
    logic                      in_ready;
    logic [2:0]                in_vsew;
    logic                      in_vm;
    logic [DATA_LEN-1:0]       in_length;
    logic [VREG_ADDR-1:0]      in_vd;
    logic [VLEN-1:0]           in_old_vd;
    logic [VLEN-1:0]           in_mask;
    logic [VLEN-1:0]           in_vs1;
    logic [VLEN-1:0]           in_vs2;
    logic [VLEN-1:0]           in_vs3;
    logic [SCALAR_REG_LEN-1:0] in_imm;
    logic [SCALAR_REG_LEN-1:0] in_rs;
    logic [3:0]                in_alu_signal;
    logic [1:0]                in_operand_type;
    logic [4:0]                in_ext_type;
    logic [5:0]                in_funct6;

    logic                      vfu_execute;
    logic [2:0]                vfu_vsew;
    logic                      vfu_vm;
    logic [DATA_LEN-1:0]       vfu_length;
    logic [VREG_ADDR-1:0]      vfu_vd;
    logic [VLEN-1:0]           vfu_old_vd;
    logic [VLEN-1:0]           vfu_mask;
    logic [VLEN-1:0]           vfu_vs1;
    logic [VLEN-1:0]           vfu_vs2;
    logic [VLEN-1:0]           vfu_vs3;
    logic [SCALAR_REG_LEN-1:0] vfu_imm;
    logic [SCALAR_REG_LEN-1:0] vfu_rs;
    logic [3:0]                vfu_alu_signal;
    logic [1:0]                vfu_operand_type;
    logic [4:0]                vfu_ext_type;
    logic [5:0]                vfu_funct6;
    logic [1:0]                vfu_status;
    logic                      vfu_is_mask;
    logic [VLEN-1:0]           vfu_result;

    logic                      vrf_we;
    logic [VREG_ADDR-1:0]      vrf_waddr;
    logic [VLEN-1:0]           vrf_wdata;
    logic                      vrf_wready;
    logic                      done;

    modport master (
        input  in_valid, in_vsew, in_vm, in_length, in_vd, in_old_vd, in_mask,
               in_vs1, in_vs2, in_vs3, in_imm, in_rs, in_alu_signal,
               in_operand_type, in_ext_type, in_funct6,
               vfu_status, vfu_is_mask, vfu_result, vrf_wready,
        output in_ready, vfu_execute, vfu_vsew, vfu_vm, vfu_length, vfu_vd,
               vfu_old_vd, vfu_mask, vfu_vs1, vfu_vs2, vfu_vs3, vfu_imm, vfu_rs,
               vfu_alu_signal, vfu_operand_type, vfu_ext_type, vfu_funct6,
               vrf_we, vrf_waddr, vrf_wdata, done
    );

    modport slave (
        output in_valid, in_vsew, in_vm, in_length, in_vd, in_old_vd, in_mask,
               in_vs1, in_vs2, in_vs3, in_imm, in_rs, in_alu_signal,
               in_operand_type, in_ext_type, in_funct6,
               vfu_status, vfu_is_mask, vfu_result, vrf_wready,
        input  in_ready, vfu_execute, vfu_vsew, vfu_vm, vfu_length, vfu_vd,
               vfu_old_vd, vfu_mask, vfu_vs1, vfu_vs2, vfu_vs3, vfu_imm, vfu_rs,
               vfu_alu_signal, vfu_operand_type, vfu_ext_type, vfu_funct6,
               vrf_we, vrf_waddr, vrf_wdata, done
    );

endinterface

// File: rtl/vector_merge_unit.sv
// Combinational merge of a VFU result into the old destination register.
//   vsew_i    : SEW code (unknown codes behave as one byte)
//   vm_i      : 1 = unmasked
//   is_mask_i : result is one bit per element
//   length_i  : vl, clamped internally to VLMAX = VLEN/SEW
//   mask_i    : v0 contents
//   old_vd_i  : current destination contents
//   result_i  : VFU result
//   merged_o  : active elements/bits take the result, the rest keep old_vd
module vector_merge_unit
    import vector_exec_ctrl_pkg::*;
#(
    parameter int unsigned VLEN  = DEFAULT_VLEN,
    parameter int unsigned LEN_W = DEFAULT_DATA_LEN
) (
    input  logic [2:0]       vsew_i,
    input  logic             vm_i,
    input  logic             is_mask_i,
    input  logic [LEN_W-1:0] length_i,
    input  logic [VLEN-1:0]  mask_i,
    input  logic [VLEN-1:0]  old_vd_i,
    input  logic [VLEN-1:0]  result_i,
    output logic [VLEN-1:0]  merged_o
);
    localparam int unsigned IDX_W = $clog2(VLEN);

    logic [31:0] shift;
    logic [31:0] vlmax;
    logic [31:0] vl_eff;
    logic [31:0] idx;

    always_comb begin
        shift  = sew_shift(vsew_i);
        vlmax  = VLEN >> shift;
        vl_eff = (32'(length_i) < vlmax) ? 32'(length_i) : vlmax;
    end

    // Bit b belongs to element b>>log2(SEW); for mask results every bit is its own element.
    always_comb begin
        merged_o = old_vd_i;
        idx      = '0;
        for (int unsigned b = 0; b < VLEN; b++) begin
            idx = is_mask_i ? b : (b >> shift);
            if (idx < vl_eff && (vm_i || mask_i[idx[IDX_W-1:0]])) begin
                merged_o[b[IDX_W-1:0]] = result_i[b[IDX_W-1:0]];
            end
        end
    end

endmodule

// File: rtl/vector_exec_ctrl.sv
// Initiator side of the VFU execute/status protocol.
//   clk, rst : clock and synchronous active-high reset
//   rdy_in   : global enable, all state and outputs hold while low
//   bus      : decoded op input (in_*), VFU request/status (vfu_*), VRF write (vrf_*), done
// Flow: IDLE accepts and latches an op, ISSUE pulses vfu_execute once the VFU is not
// busy, WAIT captures the merged result on FINISHED, WRITE holds the VRF write until
// vrf_wready, then done pulses one cycle later. vl == 0 skips the VFU and rewrites old_vd.
module vector_exec_ctrl
    import vector_exec_ctrl_pkg::*;
#(
    parameter int unsigned DATA_LEN       = DEFAULT_DATA_LEN,
    parameter int unsigned VECTOR_SIZE    = DEFAULT_VECTOR_SIZE,
    parameter int unsigned SCALAR_REG_LEN = DEFAULT_SCALAR_REG_LEN,
    parameter int unsigned VREG_ADDR      = DEFAULT_VREG_ADDR
) (
    input logic                clk,
    input logic                rst,
    input logic                rdy_in,
    vector_exec_ctrl_if.master bus
);
    localparam int unsigned VLEN = VECTOR_SIZE * DATA_LEN;

    state_e                    state_q;
    logic                      first_wait_q;
    logic                      in_ready_q;
    logic                      vfu_execute_q;
    logic                      vrf_we_q;
    logic [VREG_ADDR-1:0]      vrf_waddr_q;
    logic [VLEN-1:0]           vrf_wdata_q;
    logic                      done_q;

    logic [2:0]                vsew_q;
    logic                      vm_q;
    logic [DATA_LEN-1:0]       length_q;
    logic [VREG_ADDR-1:0]      vd_q;
    logic [VLEN-1:0]           old_vd_q;
    logic [VLEN-1:0]           mask_q;
    logic [VLEN-1:0]           vs1_q;
    logic [VLEN-1:0]           vs2_q;
    logic [VLEN-1:0]           vs3_q;
    logic [SCALAR_REG_LEN-1:0] imm_q;
    logic [SCALAR_REG_LEN-1:0] rs_q;
    logic [3:0]                alu_signal_q;
    logic [1:0]                operand_type_q;
    logic [4:0]                ext_type_q;
    logic [5:0]                funct6_q;

    logic [VLEN-1:0]           merged_d;

    vector_merge_unit #(
        .VLEN  (VLEN),
        .LEN_W (DATA_LEN)
    ) u_merge (
        .vsew_i    (vsew_q),
        .vm_i      (vm_q),
        .is_mask_i (bus.vfu_is_mask),
        .length_i  (length_q),
        .mask_i    (mask_q),
        .old_vd_i  (old_vd_q),
        .result_i  (bus.vfu_result),
        .merged_o  (merged_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            first_wait_q   <= 1'b0;
            in_ready_q     <= 1'b1;
            vfu_execute_q  <= 1'b0;
            vrf_we_q       <= 1'b0;
            vrf_waddr_q    <= '0;
            vrf_wdata_q    <= '0;
            done_q         <= 1'b0;
            vsew_q         <= '0;
            vm_q           <= 1'b0;
            length_q       <= '0;
            vd_q           <= '0;
            old_vd_q       <= '0;
            mask_q         <= '0;
            vs1_q          <= '0;
            vs2_q          <= '0;
            vs3_q          <= '0;
            imm_q          <= '0;
            rs_q           <= '0;
            alu_signal_q   <= '0;
            operand_type_q <= '0;
            ext_type_q     <= '0;
            funct6_q       <= '0;
        end else if (rdy_in) begin
            vfu_execute_q <= 1'b0;
            done_q        <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        vsew_q         <= bus.in_vsew;
                        vm_q           <= bus.in_vm;
                        length_q       <= bus.in_length;
                        vd_q           <= bus.in_vd;
                        old_vd_q       <= bus.in_old_vd;
                        mask_q         <= bus.in_mask;
                        vs1_q          <= bus.in_vs1;
                        vs2_q          <= bus.in_vs2;
                        vs3_q          <= bus.in_vs3;
                        imm_q          <= bus.in_imm;
                        rs_q           <= bus.in_rs;
                        alu_signal_q   <= bus.in_alu_signal;
                        operand_type_q <= bus.in_operand_type;
                        ext_type_q     <= bus.in_ext_type;
                        funct6_q       <= bus.in_funct6;
                        in_ready_q     <= 1'b0;
                        if (bus.in_length == '0) begin
                            vrf_we_q    <= 1'b1;
                            vrf_waddr_q <= bus.in_vd;
                            vrf_wdata_q <= bus.in_old_vd;
                            state_q     <= ST_WRITE;
                        end else begin
                            state_q <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (bus.vfu_status == VEC_ALU_NOP || bus.vfu_status == VEC_ALU_FINISHED) begin
                        vfu_execute_q <= 1'b1;
                        first_wait_q  <= 1'b1;
                        state_q       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // The VFU may still report FINISHED from the previous op while it
                    // registers the new request, so the first WAIT cycle is skipped.
                    if (first_wait_q) begin
                        first_wait_q <= 1'b0;
                    end else if (bus.vfu_status == VEC_ALU_FINISHED) begin
                        vrf_we_q    <= 1'b1;
                        vrf_waddr_q <= vd_q;
                        vrf_wdata_q <= merged_d;
                        state_q     <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (bus.vrf_wready) begin
                        vrf_we_q   <= 1'b0;
                        done_q     <= 1'b1;
                        in_ready_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready         = in_ready_q;
    assign bus.vfu_execute      = vfu_execute_q;
    assign bus.vfu_vsew         = vsew_q;
    assign bus.vfu_vm           = vm_q;
    assign bus.vfu_length       = length_q;
    assign bus.vfu_vd           = vd_q;
    assign bus.vfu_old_vd       = old_vd_q;
    assign bus.vfu_mask         = mask_q;
    assign bus.vfu_vs1          = vs1_q;
    assign bus.vfu_vs2          = vs2_q;
    assign bus.vfu_vs3          = vs3_q;
    assign bus.vfu_imm          = imm_q;
    assign bus.vfu_rs           = rs_q;
    assign bus.vfu_alu_signal   = alu_signal_q;
    assign bus.vfu_operand_type = operand_type_q;
    assign bus.vfu_ext_type     = ext_type_q;
    assign bus.vfu_funct6       = funct6_q;
    assign bus.vrf_we           = vrf_we_q;
    assign bus.vrf_waddr        = vrf_waddr_q;
    assign bus.vrf_wdata        = vrf_wdata_q;
    assign bus.done             = done_q;

endmodule
